// File: rtl/dac_channel_scheduler.sv
// Two-channel MCP4822 update scheduler: round-robin grant, SPI mode 0 frame shifter, inter-frame CS gap.
// Optional LDAC_SYNC_EN: adds ldac_n, pulsed low once both channels have been written since the last pulse.
module dac_channel_scheduler #(
  parameter int SPI_DIV = 8,
  parameter int CS_GAP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_a,
  input  logic [11:0] data_a,
  output logic        ack_a,
  input  logic        req_b,
  input  logic [11:0] data_b,
  output logic        ack_b,
  output logic        busy,
`ifdef LDAC_SYNC_EN
  output logic        ldac_n,
`endif
  output logic        spi_cs_n,
  output logic        spi_sck,
  output logic        spi_mosi
);

  localparam int DIV_W = (SPI_DIV > 1) ? $clog2(SPI_DIV) : 1;
  localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       bit_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      shreg;
  logic             last_b;
  logic             grant_a;
  logic             grant_b;
  logic             half_done;

  // last_b also names the channel of the frame in flight once a grant is made
  always_comb begin
    grant_a   = req_a && (!req_b || last_b);
    grant_b   = req_b && !grant_a;
    half_done = (div_cnt == DIV_W'(SPI_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      shreg    <= '0;
      last_b   <= 1'b1;
      ack_a    <= 1'b0;
      ack_b    <= 1'b0;
      busy     <= 1'b0;
      spi_cs_n <= 1'b1;
      spi_sck  <= 1'b0;
      spi_mosi <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_a || grant_b) begin
            shreg    <= grant_a ? {4'b0011, data_a} : {4'b1011, data_b};
            spi_mosi <= grant_b;
            ack_a    <= grant_a;
            ack_b    <= grant_b;
            last_b   <= grant_b;
            spi_cs_n <= 1'b0;
            busy     <= 1'b1;
            div_cnt  <= '0;
            bit_cnt  <= '0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (half_done) begin
            div_cnt <= '0;
            if (!spi_sck) begin
              spi_sck <= 1'b1;
            end else begin
              spi_sck <= 1'b0;
              // 16th falling edge closes the frame; otherwise present the next bit
              if (bit_cnt == 4'd15) begin
                spi_cs_n <= 1'b1;
                spi_mosi <= 1'b0;
                gap_cnt  <= '0;
                state    <= GAP;
              end else begin
                bit_cnt  <= bit_cnt + 4'd1;
                shreg    <= shreg << 1;
                spi_mosi <= shreg[14];
              end
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        GAP: begin
          if (gap_cnt == GAP_W'(CS_GAP - 1)) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef LDAC_SYNC_EN
  logic frame_end;
  logic wr_a;
  logic wr_b;
  logic ldac_cnt;

  always_comb begin
    frame_end = (state == SHIFT) && half_done && spi_sck && (bit_cnt == 4'd15);
  end

  // Flags are set in SHIFT and consumed in GAP, so set and clear never collide
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldac_n   <= 1'b1;
      ldac_cnt <= 1'b0;
      wr_a     <= 1'b0;
      wr_b     <= 1'b0;
    end else begin
      if (frame_end) begin
        if (last_b) wr_b <= 1'b1;
        else        wr_a <= 1'b1;
      end
      if (state == GAP && wr_a && wr_b && ldac_n) begin
        ldac_n   <= 1'b0;
        ldac_cnt <= 1'b1;
        wr_a     <= 1'b0;
        wr_b     <= 1'b0;
      end else if (!ldac_n) begin
        if (ldac_cnt) ldac_cnt <= 1'b0;
        else          ldac_n   <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Directed bench for dac_channel_scheduler: frame content/length, round-robin order, gap timing, async reset.
// Define LDAC_SYNC_EN for this file as well as the RTL to exercise the ldac_n pulse.
module tb_dac_channel_scheduler;

  logic        clk;
  logic        rst_n;
  logic        req_a;
  logic [11:0] data_a;
  logic        ack_a;
  logic        req_b;
  logic [11:0] data_b;
  logic        ack_b;
  logic        busy;
  logic        spi_cs_n;
  logic        spi_sck;
  logic        spi_mosi;
`ifdef LDAC_SYNC_EN
  logic        ldac_n;
  int          ldac_lows;
`endif

  int   total;
  int   bad;
  logic auto_drop;

  dac_channel_scheduler #(.SPI_DIV(8), .CS_GAP(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_a    (req_a),
    .data_a   (data_a),
    .ack_a    (ack_a),
    .req_b    (req_b),
    .data_b   (data_b),
    .ack_b    (ack_b),
    .busy     (busy),
`ifdef LDAC_SYNC_EN
    .ldac_n   (ldac_n),
`endif
    .spi_cs_n (spi_cs_n),
    .spi_sck  (spi_sck),
    .spi_mosi (spi_mosi)
  );

  always #5 clk = ~clk;

`ifdef LDAC_SYNC_EN
  always @(negedge clk) if (!ldac_n) ldac_lows++;
`endif

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic ra, input logic rb, input logic [11:0] da, input logic [11:0] db);
    @(negedge clk);
    data_a = da;
    data_b = db;
    req_a  = ra;
    req_b  = rb;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Samples on falling clk: counts high cycles before CS drops, then decodes the frame at each sck rise
  task automatic capture_frame(output logic [15:0] word, output int low, output int rises,
                               output int na, output int nb, output int gap, output int to);
    logic prev_sck;
    word = '0; low = 0; rises = 0; na = 0; nb = 0; gap = 0; to = 0; prev_sck = 1'b0;
    @(negedge clk);
    while (spi_cs_n && gap < 2000) begin
      gap++;
      @(negedge clk);
    end
    if (spi_cs_n) begin
      to = 1;
      return;
    end
    while (!spi_cs_n && low < 10000) begin
      low++;
      if (ack_a) begin na++; if (auto_drop) req_a = 1'b0; end
      if (ack_b) begin nb++; if (auto_drop) req_b = 1'b0; end
      if (spi_sck && !prev_sck) begin
        word = {word[14:0], spi_mosi};
        rises++;
      end
      prev_sck = spi_sck;
      @(negedge clk);
    end
    if (!spi_cs_n) to = 1;
  endtask

  initial begin
    logic [15:0] word;
    int low, rises, na, nb, gap, to, n, cnt;
    logic [15:0] exp_words [4];
    exp_words[0] = 16'h35A5;
    exp_words[1] = 16'hBA5A;
    exp_words[2] = 16'h35A5;
    exp_words[3] = 16'hBA5A;
    total = 0; bad = 0; auto_drop = 1'b1;
    clk = 1'b0; rst_n = 1'b1;
    req_a = 1'b0; req_b = 1'b0; data_a = '0; data_b = '0;

    #2 rst_n = 1'b0;
    #1;
    check_output("rst_cs_n", spi_cs_n, 1);
    check_output("rst_sck", spi_sck, 0);
    check_output("rst_mosi", spi_mosi, 0);
    check_output("rst_ack_a", ack_a, 0);
    check_output("rst_ack_b", ack_b, 0);
    check_output("rst_busy", busy, 0);
`ifdef LDAC_SYNC_EN
    check_output("rst_ldac_n", ldac_n, 1);
`endif
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single A frame 0xABC");
    apply_stimulus(1'b1, 1'b0, 12'hABC, 12'h000);
    capture_frame(word, low, rises, na, nb, gap, to);
    check_output("a1_timeout", to, 0);
    check_output("a1_word", word, 16'h3ABC);
    check_output("a1_cs_low", low, 256);
    check_output("a1_rises", rises, 16);
    check_output("a1_acks_a", na, 1);
    check_output("a1_acks_b", nb, 0);
    check_output("a1_busy_gap", busy, 1);
    repeat (5) @(negedge clk);
    check_output("a1_idle_busy", busy, 0);
    check_output("a1_idle_cs", spi_cs_n, 1);
    check_output("a1_idle_sck", spi_sck, 0);
    check_output("a1_idle_mosi", spi_mosi, 0);

    $display("[TB] simultaneous A/B after reset");
    do_reset();
    apply_stimulus(1'b1, 1'b1, 12'h123, 12'h456);
    capture_frame(word, low, rises, na, nb, gap, to);
    check_output("tie1_timeout", to, 0);
    check_output("tie1_word", word, 16'h3123);
    check_output("tie1_acks_a", na, 1);
    capture_frame(word, low, rises, na, nb, gap, to);
    check_output("tie2_timeout", to, 0);
    check_output("tie2_word", word, 16'hB456);
    check_output("tie2_acks_b", nb, 1);
    check_output("tie2_cs_high", gap + 1, 3);

    $display("[TB] both requests held for four frames");
    auto_drop = 1'b0;
    data_a = 12'h5A5;
    data_b = 12'hA5A;
    req_a  = 1'b1;
    req_b  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      capture_frame(word, low, rises, na, nb, gap, to);
      check_output($sformatf("rr%0d_timeout", i), to, 0);
      check_output($sformatf("rr%0d_word", i), word, {16'h0, exp_words[i]});
      check_output($sformatf("rr%0d_acks", i), na + nb, 1);
    end
    req_a = 1'b0;
    req_b = 1'b0;
    auto_drop = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (!spi_cs_n) cnt++; end
    check_output("rr_no_extra", cnt, 0);

    $display("[TB] reset in the middle of a frame");
    apply_stimulus(1'b1, 1'b0, 12'h7E1, 12'h000);
    n = 0;
    while (!ack_a && n < 10) begin @(negedge clk); n++; end
    check_output("mid_ack_seen", ack_a, 1);
    req_a = 1'b0;
    repeat (140) @(negedge clk);
    check_output("mid_in_frame", spi_cs_n, 0);
    rst_n = 1'b0;
    #1;
    check_output("mid_rst_cs", spi_cs_n, 1);
    check_output("mid_rst_sck", spi_sck, 0);
    check_output("mid_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (20) begin @(negedge clk); if (ack_a || ack_b || !spi_cs_n || busy) cnt++; end
    check_output("mid_post_idle", cnt, 0);

    $display("[TB] B raised during an A frame");
    apply_stimulus(1'b1, 1'b0, 12'h0F0, 12'h000);
    n = 0;
    while (!ack_a && n < 10) begin @(negedge clk); n++; end
    check_output("bdur_ack_a", ack_a, 1);
    req_a = 1'b0;
    repeat (20) @(negedge clk);
    data_b = 12'h9C3;
    req_b  = 1'b1;
    capture_frame(word, low, rises, na, nb, gap, to);
    check_output("bdur_a_timeout", to, 0);
    capture_frame(word, low, rises, na, nb, gap, to);
    check_output("bdur_b_timeout", to, 0);
    check_output("bdur_b_word", word, 16'hB9C3);
    check_output("bdur_b_acks", nb, 1);
    check_output("bdur_cs_high", gap + 1, 3);
    cnt = 0;
    repeat (300) begin @(negedge clk); if (!spi_cs_n) cnt++; end
    check_output("bdur_no_dup", cnt, 0);

`ifdef LDAC_SYNC_EN
    $display("[TB] ldac sync: A, A, B");
    do_reset();
    #1 ldac_lows = 0;
    check_output("ldac_after_rst", ldac_n, 1);
    apply_stimulus(1'b1, 1'b0, 12'h111, 12'h000);
    capture_frame(word, low, rises, na, nb, gap, to);
    repeat (10) @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 12'h222, 12'h000);
    capture_frame(word, low, rises, na, nb, gap, to);
    repeat (10) @(negedge clk);
    check_output("ldac_none_yet", ldac_lows, 0);
    apply_stimulus(1'b0, 1'b1, 12'h000, 12'h333);
    capture_frame(word, low, rises, na, nb, gap, to);
    check_output("ldac_b_word", word, 16'hB333);
    repeat (10) @(negedge clk);
    check_output("ldac_pulse_len", ldac_lows, 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
